// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_arb_pkg
// Description : Shared constants and request record for the GPR write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_arb_pkg;

    localparam int REG_AW         = 5;
    localparam int DATA_W         = 32;
    localparam int NUM_GPR        = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef struct packed {
        logic [REG_AW-1:0] a3;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wr_req_t;

endpackage : rf_arb_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Pending-write busy bits for long-op destinations, with claim
//               check and two combinational hazard query ports.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import rf_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              set_valid,
    input  logic [REG_AW-1:0] set_a3,
    output logic              set_ok,
    input  logic              clr_valid,
    input  logic [REG_AW-1:0] clr_a3,
    input  logic [REG_AW-1:0] q_a1,
    input  logic [REG_AW-1:0] q_a2,
    output logic              q_busy1,
    output logic              q_busy2
);

    // Bit 0 is never written after reset, so $0 always reads idle.
    logic [NUM_GPR-1:0] r_busy;
    logic               w_set;

    assign set_ok = (set_a3 == '0) || !r_busy[set_a3];
    assign w_set  = set_valid && set_ok && (set_a3 != '0);

    // A same-cycle set beats the clear: the new claim is younger than the
    // write that is retiring.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < NUM_GPR; i++) begin
                if (w_set && (set_a3 == REG_AW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (clr_valid && (clr_a3 == REG_AW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign q_busy1 = r_busy[q_a1] && (q_a1 != '0);
    assign q_busy2 = r_busy[q_a2] && (q_a2 != '0);

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Shares the GPR write port between writeback (primary) and the
//               multi-cycle unit (secondary), with a starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_valid,
    output logic              p_ready,
    input  logic [REG_AW-1:0] p_a3,
    input  logic [DATA_W-1:0] p_wd,
    input  logic [DATA_W-1:0] p_pc,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [REG_AW-1:0] s_a3,
    input  logic [DATA_W-1:0] s_wd,
    input  logic [DATA_W-1:0] s_pc,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_a3,
    output logic              iss_ok,
    input  logic [REG_AW-1:0] q_a1,
    input  logic [REG_AW-1:0] q_a2,
    output logic              q_busy1,
    output logic              q_busy2,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd,
    output logic [DATA_W-1:0] rf_pc
);

    localparam logic [CNT_W-1:0] C_CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_STARVE  = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_force;
    logic             w_s_grant;
    logic             w_p_grant;
    wr_req_t          w_p_req;
    wr_req_t          w_s_req;
    wr_req_t          w_win;
    logic             r_we;
    wr_req_t          r_out;

    assign w_force   = s_valid && (r_wait_cnt >= C_STARVE);
    assign w_s_grant = s_valid && (!p_valid || w_force);
    assign w_p_grant = p_valid && !w_s_grant;

    assign p_ready = w_p_grant;
    assign s_ready = w_s_grant;

    assign w_p_req = '{a3: p_a3, wd: p_wd, pc: p_pc};
    assign w_s_req = '{a3: s_a3, wd: s_wd, pc: s_pc};
    assign w_win   = w_s_grant ? w_s_req : w_p_req;

    // Counts only consecutive losing cycles of a waiting secondary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (s_valid && !w_s_grant) begin
            if (r_wait_cnt != C_CNT_SAT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Address/data/PC hold when idle so the write log sees a stable bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we  <= 1'b0;
            r_out <= '0;
        end else begin
            r_we <= w_p_grant || w_s_grant;
            if (w_p_grant || w_s_grant) begin
                r_out <= w_win;
            end
        end
    end

    assign rf_we = r_we;
    assign rf_a3 = r_out.a3;
    assign rf_wd = r_out.wd;
    assign rf_pc = r_out.pc;

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_valid (iss_valid),
        .set_a3    (iss_a3),
        .set_ok    (iss_ok),
        .clr_valid (w_s_grant),
        .clr_a3    (s_a3),
        .q_a1      (q_a1),
        .q_a2      (q_a2),
        .q_busy1   (q_busy1),
        .q_busy2   (q_busy2)
    );

endmodule : rf_write_arbiter
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Directed vector table plus hand sequences for rf_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_valid, s_valid, iss_valid;
    logic        p_ready, s_ready, iss_ok, q_busy1, q_busy2;
    logic [4:0]  p_a3, s_a3, iss_a3, q_a1, q_a2;
    logic [31:0] p_wd, p_pc, s_wd, s_pc;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd, rf_pc;

    int n_applied = 0;
    int n_miss    = 0;

    typedef struct {
        logic pv; logic [4:0] pa; logic [31:0] pwd; logic [31:0] ppc;
        logic sv; logic [4:0] sa; logic [31:0] swd; logic [31:0] spc;
        logic iv; logic [4:0] ia; logic [4:0] q1; logic [4:0] q2;
        logic e_pr; logic e_sr; logic e_ok; logic e_b1; logic e_b2;
        logic e_we; logic [4:0] e_a3; logic [31:0] e_wd; logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 14;
    vec_t vec [NV];

    rf_write_arbiter #(.STARVE_MAX(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .p_valid(p_valid), .p_ready(p_ready), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc),
        .s_valid(s_valid), .s_ready(s_ready), .s_a3(s_a3), .s_wd(s_wd), .s_pc(s_pc),
        .iss_valid(iss_valid), .iss_a3(iss_a3), .iss_ok(iss_ok),
        .q_a1(q_a1), .q_a2(q_a2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_pc(rf_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        p_valid = 0; p_a3 = 0; p_wd = 0; p_pc = 0;
        s_valid = 0; s_a3 = 0; s_wd = 0; s_pc = 0;
        iss_valid = 0; iss_a3 = 0; q_a1 = 0; q_a2 = 0;
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] a3,
                          input logic [31:0] wd, input logic [31:0] pc);
        chk({tag, " rf_we"}, 32'(rf_we), 32'(we));
        chk({tag, " rf_a3"}, 32'(rf_a3), 32'(a3));
        chk({tag, " rf_wd"}, rf_wd, wd);
        chk({tag, " rf_pc"}, rf_pc, pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        pv pa  pwd      ppc       sv sa  swd      spc       iv ia q1 q2 pr sr ok b1 b2 we a3  wd       pc
        vec[0]  = '{0, 0, 0,       0,        0, 0, 0,       0,        0, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0,       0};
        vec[1]  = '{1, 8, 'h1234,  'h3000,   0, 0, 0,       0,        0, 0, 8, 0, 1, 0, 1, 0, 0, 1, 8, 'h1234,  'h3000};
        vec[2]  = '{0, 0, 0,       0,        0, 0, 0,       0,        0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8, 'h1234,  'h3000};
        vec[3]  = '{0, 0, 0,       0,        0, 0, 0,       0,        1, 9, 9, 0, 0, 0, 1, 0, 0, 0, 8, 'h1234,  'h3000};
        vec[4]  = '{1, 3, 'hAAAA,  'h3004,   0, 0, 0,       0,        1, 9, 9, 9, 1, 0, 0, 1, 1, 1, 3, 'hAAAA,  'h3004};
        vec[5]  = '{1, 4, 1,       'h3008,   1, 9, 'h9999,  'h4000,   0, 0, 9, 8, 1, 0, 1, 1, 0, 1, 4, 1,       'h3008};
        vec[6]  = '{1, 4, 2,       'h300C,   1, 9, 'h9999,  'h4000,   0, 0, 9, 0, 1, 0, 1, 1, 0, 1, 4, 2,       'h300C};
        vec[7]  = '{1, 4, 3,       'h3010,   1, 9, 'h9999,  'h4000,   0, 0, 9, 0, 1, 0, 1, 1, 0, 1, 4, 3,       'h3010};
        vec[8]  = '{1, 4, 4,       'h3014,   1, 9, 'h9999,  'h4000,   0, 0, 9, 0, 1, 0, 1, 1, 0, 1, 4, 4,       'h3014};
        vec[9]  = '{1, 4, 5,       'h3018,   1, 9, 'h9999,  'h4000,   0, 0, 9, 0, 0, 1, 1, 1, 0, 1, 9, 'h9999,  'h4000};
        vec[10] = '{1, 4, 5,       'h3018,   0, 0, 0,       0,        0, 0, 9, 0, 1, 0, 1, 0, 0, 1, 4, 5,       'h3018};
        vec[11] = '{1, 6, 6,       'h301C,   1, 10, 'h10,   'h4004,   0, 0, 9, 0, 1, 0, 1, 0, 0, 1, 6, 6,       'h301C};
        vec[12] = '{0, 0, 0,       0,        1, 10, 'h10,   'h4004,   0, 0, 10, 0, 0, 1, 1, 0, 0, 1, 10, 'h10,  'h4004};
        vec[13] = '{0, 0, 0,       0,        0, 0, 0,       0,        0, 0, 10, 0, 0, 0, 1, 0, 0, 0, 10, 'h10,  'h4004};

        idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_rf("por", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            p_valid = vec[k].pv;  p_a3 = vec[k].pa;  p_wd = vec[k].pwd;  p_pc = vec[k].ppc;
            s_valid = vec[k].sv;  s_a3 = vec[k].sa;  s_wd = vec[k].swd;  s_pc = vec[k].spc;
            iss_valid = vec[k].iv; iss_a3 = vec[k].ia; q_a1 = vec[k].q1; q_a2 = vec[k].q2;
            #1;
            chk($sformatf("v%0d p_ready", k), 32'(p_ready), 32'(vec[k].e_pr));
            chk($sformatf("v%0d s_ready", k), 32'(s_ready), 32'(vec[k].e_sr));
            chk($sformatf("v%0d iss_ok", k),  32'(iss_ok),  32'(vec[k].e_ok));
            chk($sformatf("v%0d q_busy1", k), 32'(q_busy1), 32'(vec[k].e_b1));
            chk($sformatf("v%0d q_busy2", k), 32'(q_busy2), 32'(vec[k].e_b2));
            @(posedge clk);
            #1;
            chk_rf($sformatf("v%0d", k), vec[k].e_we, vec[k].e_a3, vec[k].e_wd, vec[k].e_pc);
        end

        // Claim and retire of the same register in one cycle: claim survives.
        @(negedge clk);
        idle();
        s_valid = 1; s_a3 = 9; s_wd = 'h77; s_pc = 'h5000;
        iss_valid = 1; iss_a3 = 9; q_a1 = 9;
        #1;
        chk("setclr iss_ok", 32'(iss_ok), 1);
        chk("setclr s_ready", 32'(s_ready), 1);
        chk("setclr q_busy1 pre", 32'(q_busy1), 0);
        @(posedge clk);
        #1;
        chk_rf("setclr", 1, 9, 'h77, 'h5000);
        @(negedge clk);
        idle();
        q_a1 = 9;
        s_valid = 1; s_a3 = 9; s_wd = 'h88; s_pc = 'h5004;
        #1;
        chk("setclr q_busy1 held", 32'(q_busy1), 1);
        chk("retire s_ready", 32'(s_ready), 1);
        @(posedge clk);
        #1;
        chk_rf("retire", 1, 9, 'h88, 'h5004);
        @(negedge clk);
        idle();
        q_a1 = 9;
        #1;
        chk("retire q_busy1", 32'(q_busy1), 0);

        // $0 traffic is forwarded and never claims a busy bit.
        @(negedge clk);
        idle();
        s_valid = 1; s_a3 = 0; s_wd = 'h55; s_pc = 'h6000;
        iss_valid = 1; iss_a3 = 0; q_a1 = 0; q_a2 = 9;
        #1;
        chk("zero iss_ok", 32'(iss_ok), 1);
        chk("zero s_ready", 32'(s_ready), 1);
        chk("zero q_busy1", 32'(q_busy1), 0);
        chk("zero q_busy2", 32'(q_busy2), 0);
        @(posedge clk);
        #1;
        chk_rf("zero", 1, 0, 'h55, 'h6000);
        @(negedge clk);
        idle();
        iss_a3 = 9; q_a2 = 9;
        #1;
        chk("zero iss_ok r9", 32'(iss_ok), 1);

        // Mid-stream reset: busy[5] claimed and the starvation counter part-way up.
        @(negedge clk);
        idle();
        iss_valid = 1; iss_a3 = 5;
        p_valid = 1; p_a3 = 1; p_wd = 'hA1; p_pc = 'h7000;
        s_valid = 1; s_a3 = 2; s_wd = 'hB2; s_pc = 'h8000;
        @(posedge clk);
        @(negedge clk);
        iss_valid = 0; q_a1 = 5;
        #1;
        chk("prerst q_busy1", 32'(q_busy1), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_rf("midrst", 0, 0, 0, 0);
        chk("midrst q_busy1", 32'(q_busy1), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("postrst rf_we", 32'(rf_we), 0);
        chk("postrst q_busy1", 32'(q_busy1), 0);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk($sformatf("postrst c%0d p_ready", c), 32'(p_ready), (c < 4) ? 1 : 0);
            chk($sformatf("postrst c%0d s_ready", c), 32'(s_ready), (c < 4) ? 0 : 1);
            @(posedge clk);
        end
        #1;
        chk_rf("postrst swin", 1, 2, 'hB2, 'h8000);

        @(negedge clk);
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule : tb_rf_write_arbiter
`default_nettype wire
